d16_execute: RTL
================

// Module: d16_execute
// PURPOSE
// - Execute stage of the d16 core: consumes the two register-file read operands (qa/qb) plus a
//   decoded opcode and destination, and produces the write-back triple (w, addr_w, data) that
//   drives the register file write port directly.
// - Single-cycle ALU ops issue back to back; MUL is a 16-cycle sequential shift-add that stalls
//   issue via in_ready.
// PARAMETERS
// - WIDTH      16   datapath width; only 16 is supported
// - MUL_CYCLES 16   MUL iterations, one per bit of qb; must equal WIDTH
// PORTS
// - sys_clk    in   1   single clock; all state updates on rising edge
// - sys_rst_n  in   1   asynchronous, active-low reset
// - in_valid   in   1   opcode/operands valid this cycle
// - in_ready   out  1   stage can accept; transfer occurs when in_valid & in_ready
// - in_op      in   4   opcode, encodings listed under BEHAVIOUR
// - in_dst     in   4   destination register index
// - in_a       in   16  operand A (register file qa)
// - in_b       in   16  operand B (register file qb)
// - flush      in   1   abort in-flight work, no write-back
// - wb_w       out  1   one-cycle write strobe to register file w
// - wb_addr    out  4   destination to register file addr_w
// - wb_data    out  16  result to register file data
// - flag_z     out  1   zero flag of last written result
// - flag_c     out  1   carry flag of last written result
// - illegal    out  1   one-cycle pulse: reserved opcode accepted
// BEHAVIOUR
// - Reset values (asynchronous): in_ready=1, wb_w=0, wb_addr=0, wb_data=0, flag_z=0, flag_c=0,
//   illegal=0, state=IDLE, iteration counter=0.
// - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR, 8 SAR, 9 MUL; A-F reserved.
// - Shift amount is in_b[3:0]; all results truncated to 16 bits.
// - Carry flag:
//   - ADD: carry-out of bit 15; SUB: borrow (a<b unsigned).
//   - Shifts: last bit shifted out, 0 when amount=0; logic ops: 0.
//   - MUL: 1 if the upper 16 product bits are nonzero.
// - Zero flag: 1 when wb_data==0.
// - Flags update only in a cycle where wb_w=1.
// - States: IDLE, MUL. in_ready = (state==IDLE) & ~flush.
// - Single-cycle op accepted in cycle N: wb_w=1 with wb_addr=in_dst and the result during N+1.
//   in_ready stays 1, giving throughput of one op per cycle.
// - MUL accepted in cycle N:
//   - Latch a, b and dst; state=MUL for cycles N+1..N+16 (in_ready=0); one multiplier bit per cycle.
//   - At the end of N+16 return to IDLE; wb_w=1 and in_ready=1 during N+17.
// - wb_w is a single-cycle pulse; wb_addr and wb_data hold their last value when wb_w=0.
// - Reserved opcode: accepted normally, wb_w stays 0, flags unchanged, illegal=1 during N+1.
// - flush=1:
//   - No transfer is accepted that cycle (flush wins over in_valid).
//   - A MUL in progress is discarded; state becomes IDLE next cycle with no wb_w.
//   - A write-back pulse already scheduled for the same cycle is not suppressed.
// - Reset asserted mid-MUL: state, counter and outputs clear immediately; no write-back occurs.
// - No internal forwarding: the register file already bypasses same-cycle write data.
// STRUCTURE
// - Shared include d16_defs.vh: opcode localparams (D16_OP_ADD..D16_OP_MUL), state encodings,
//   width constant; shared with the decoder.
// - Sub-module d16_mul_seq: start/busy/done sequential shift-add multiplier with 32-bit product.
//   Also reset by flush.
// - Top level holds the combinational ALU, the IDLE/MUL FSM and the write-back/flag registers.
// TESTING
// - ADD a=16'hFFFF b=16'h0001 dst=3 -> next cycle wb_w=1 wb_addr=3 wb_data=0, z=1, c=1.
// - Back-to-back SUB 5-7 then XOR 16'hAAAA^16'h5555 -> wb 16'hFFFE c=1, then wb 16'hFFFF c=0 z=0
//   on consecutive cycles.
// - MUL 16'h0100*16'h0200 dst=7 -> in_ready low 16 cycles, wb_data=16'h0000 c=1 z=1 exactly
//   17 cycles after accept.
// - MUL 300*200 -> wb_data=16'hEA60 c=0; second op held with in_valid=1 during MUL is accepted
//   the cycle wb_w=1.
// - flush at MUL cycle 8 -> no wb_w ever; in_ready=1 the next cycle.
//   sys_rst_n low mid-MUL -> all outputs 0 immediately.
// - SAR 16'h8001 by 1 -> 16'hC000 c=1; op=4'hC -> illegal pulse, wb_w=0, flags unchanged.

Source files
------------

// File: rtl/d16_execute_pkg.sv
// d16_execute_pkg: shared definitions for the d16 execute stage.
//   - datapath width constant
//   - opcode encodings (0..9 defined, A..F reserved)
//   - execute-stage FSM states
//   - helper functions classifying opcodes
package d16_execute_pkg;

  localparam int unsigned D16_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_SAR = 4'h8,
    OP_MUL = 4'h9
  } d16_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } d16_state_e;

  // Opcodes above MUL carry no operation.
  function automatic logic op_is_reserved(input logic [3:0] op);
    return op > OP_MUL;
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/d16_execute_mul.sv
// d16_execute_mul: sequential shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, returns to idle and drops the product
//   start      : load a/b and begin (ignored while busy)
//   a, b       : multiplicand / multiplier
//   done       : high during the final iteration cycle
//   product    : full 2*WIDTH product, valid while done is high
module d16_execute_mul
  import d16_execute_pkg::*;
#(
  parameter int unsigned WIDTH      = D16_WIDTH,
  parameter int unsigned MUL_CYCLES = D16_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(MUL_CYCLES);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;

  assign addend  = mplier[0] ? mcand : '0;
  // The final partial sum is exposed combinationally so the consumer can
  // register it on the same edge that ends the last iteration.
  assign product = acc + addend;
  assign done    = busy && (cnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end
  end

endmodule

// File: rtl/d16_execute.sv
// d16_execute: execute stage of the d16 core.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   in_valid/in_ready  : issue handshake (transfer on in_valid & in_ready)
//   in_op, in_dst      : decoded opcode and destination register
//   in_a, in_b         : register-file operands qa / qb
//   flush              : abort in-flight MUL, block issue this cycle
//   wb_w/wb_addr/wb_data : register-file write port (wb_w is a 1-cycle strobe)
//   flag_z, flag_c     : flags of the last written result
//   illegal            : 1-cycle pulse after a reserved opcode is accepted
// Single-cycle ALU ops write back the cycle after acceptance; MUL occupies
// the stage for MUL_CYCLES cycles and writes back the cycle after.
module d16_execute
  import d16_execute_pkg::*;
#(
  parameter int unsigned WIDTH      = D16_WIDTH,
  parameter int unsigned MUL_CYCLES = D16_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [3:0]       in_dst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             wb_w,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             illegal
);

  d16_state_e         state;
  logic [3:0]         mul_dst;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   alu_data;
  logic               alu_carry;
  logic [3:0]         shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH:0]     sar_ext;

  assign in_ready  = (state == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && op_is_mul(in_op);
  assign shamt     = in_b[3:0];

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit; with a zero amount that bit is the zero pad.
  assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_ext = {1'b0, in_a} - {1'b0, in_b};
  assign shl_ext  = {1'b0, in_a} << shamt;
  assign shr_ext  = {in_a, 1'b0} >> shamt;
  assign sar_ext  = $signed({in_a, 1'b0}) >>> shamt;

  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    case (in_op)
      OP_ADD: begin alu_data = sum_ext[WIDTH-1:0];  alu_carry = sum_ext[WIDTH];  end
      OP_SUB: begin alu_data = diff_ext[WIDTH-1:0]; alu_carry = diff_ext[WIDTH]; end
      OP_AND: alu_data = in_a & in_b;
      OP_OR:  alu_data = in_a | in_b;
      OP_XOR: alu_data = in_a ^ in_b;
      OP_NOT: alu_data = ~in_a;
      OP_SHL: begin alu_data = shl_ext[WIDTH-1:0]; alu_carry = shl_ext[WIDTH]; end
      OP_SHR: begin alu_data = shr_ext[WIDTH:1];   alu_carry = shr_ext[0];     end
      OP_SAR: begin alu_data = sar_ext[WIDTH:1];   alu_carry = sar_ext[0];     end
      default: ;
    endcase
  end

  d16_execute_mul #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .flush   (flush),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      mul_dst <= '0;
      wb_w    <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      wb_w    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_is_mul(in_op)) begin
              state   <= ST_MUL;
              mul_dst <= in_dst;
            end else if (op_is_reserved(in_op)) begin
              illegal <= 1'b1;
            end else begin
              wb_w    <= 1'b1;
              wb_addr <= in_dst;
              wb_data <= alu_data;
              flag_c  <= alu_carry;
              flag_z  <= (alu_data == '0);
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (mul_done) begin
            state   <= ST_IDLE;
            wb_w    <= 1'b1;
            wb_addr <= mul_dst;
            wb_data <= mul_product[WIDTH-1:0];
            flag_c  <= |mul_product[2*WIDTH-1:WIDTH];
            flag_z  <= (mul_product[WIDTH-1:0] == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
